dft_bin_scheduler: RTL and testbench

- Sequences one DFT_singleBin engine through a complete N-point frame for one bin k.
- Buffers incoming samples in a small FIFO and issues one engine write per sample, with n = 0..N-1.
- Waits for the engine's per-sample done before issuing the next write, then captures X and reports it.
- Sits between the sample source and the engine; owns engine reset, sequencing and error handling.

---
 rtl/dft_sched_pkg.sv | 24 ++
 rtl/dft_bin_scheduler_if.sv | 42 ++++
 rtl/dft_sample_fifo.sv | 69 ++++++
 rtl/dft_bin_scheduler.sv | 171 +++++++++++++++++
 tb/tb_dft_bin_scheduler.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dft_sched_pkg.sv
// Shared types and default constants for the single-bin DFT frame scheduler.
// The FSM state enum and the counter-width helper live here.
package dft_sched_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_N_MAX      = 1024;
  localparam int DEF_LOG_N_MAX  = 10;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    CAPTURE
  } state_e;

  // Bits needed for a counter that must be able to hold max_val (used for the WAIT timer).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dft_bin_scheduler_if.sv
// Bundles the sample-source and engine-side signals of the scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface dft_bin_scheduler_if
  import dft_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                      i_start;
  logic [WIDTH-1:0]          i_k;
  logic [WIDTH-1:0]          i_N;
  logic                      i_abort;
  logic signed [WIDTH-1:0]   i_x;
  logic                      i_x_valid;
  logic                      o_x_ready;
  logic                      o_eng_reset;
  logic                      o_eng_wr;
  logic signed [WIDTH-1:0]   o_eng_x;
  logic [WIDTH-1:0]          o_eng_k;
  logic [WIDTH-1:0]          o_eng_n;
  logic [WIDTH-1:0]          o_eng_N;
  logic                      i_eng_done;
  logic signed [2*WIDTH-1:0] i_eng_X;
  logic signed [2*WIDTH-1:0] o_X;
  logic                      o_result_valid;
  logic                      o_busy;
  logic                      o_cfg_err;
  logic                      o_timeout_err;

  modport master (
    output i_start, i_k, i_N, i_abort, i_x, i_x_valid, i_eng_done, i_eng_X,
    input  o_x_ready, o_eng_reset, o_eng_wr, o_eng_x, o_eng_k, o_eng_n, o_eng_N,
    input  o_X, o_result_valid, o_busy, o_cfg_err, o_timeout_err
  );

  modport slave (
    input  i_start, i_k, i_N, i_abort, i_x, i_x_valid, i_eng_done, i_eng_X,
    output o_x_ready, o_eng_reset, o_eng_wr, o_eng_x, o_eng_k, o_eng_n, o_eng_N,
    output o_X, o_result_valid, o_busy, o_cfg_err, o_timeout_err
  );

endinterface

// File: rtl/dft_sample_fifo.sv
// Small synchronous sample FIFO with push/pop/flush; a push in the flush cycle
// survives the flush and becomes the only entry.
module dft_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = do_push ? AW'(1) : '0;
      count_d  = do_push ? (AW + 1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      if (flush_i) mem_q[0] <= data_i;
      else         mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dft_bin_scheduler.sv
// Sequences one single-bin DFT engine through an N-sample frame for bin k:
// buffers samples, issues one engine write per sample, and captures the result.
module dft_bin_scheduler
  import dft_sched_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int N_MAX      = DEF_N_MAX,
  parameter int LOG_N_MAX  = DEF_LOG_N_MAX,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic                i_sys_clk,
  input logic                i_reset_n,
  dft_bin_scheduler_if.slave bus
);

  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [WIDTH-1:0] N_MAX_C   = WIDTH'(N_MAX);
  localparam logic [TW-1:0]    TIMEOUT_C = TW'(TIMEOUT);

  state_e                    state_q;
  logic [WIDTH-1:0]          k_q;
  logic [WIDTH-1:0]          len_q;
  logic [LOG_N_MAX:0]        n_q;
  logic [LOG_N_MAX:0]        n_next;
  logic [TW-1:0]             timer_q;

  logic                      eng_reset_q;
  logic                      eng_wr_q;
  logic signed [WIDTH-1:0]   eng_x_q;
  logic [WIDTH-1:0]          eng_k_q;
  logic [WIDTH-1:0]          eng_n_q;
  logic [WIDTH-1:0]          eng_len_q;
  logic signed [2*WIDTH-1:0] x_res_q;
  logic                      result_valid_q;
  logic                      cfg_err_q;
  logic                      timeout_err_q;

  logic                      busy;
  logic                      start_ok;
  logic                      abort_now;
  logic                      timeout_now;
  logic                      last_sample;
  logic                      x_ready;
  logic                      fifo_push, fifo_pop, fifo_flush;
  logic                      fifo_full, fifo_empty;
  logic [WIDTH-1:0]          fifo_dout;

  assign busy        = (state_q != IDLE);
  assign start_ok    = (bus.i_N != '0) && (bus.i_N <= N_MAX_C) && (bus.i_k < bus.i_N);
  assign abort_now   = bus.i_abort && busy;
  assign timeout_now = (state_q == WAIT) && !abort_now && !bus.i_eng_done &&
                       (timer_q == TIMEOUT_C);
  assign n_next      = n_q + 1'b1;
  assign last_sample = (WIDTH'(n_next) == len_q);

  // Ready follows the registered full flag, so a pop never opens a same-cycle slot.
  assign x_ready    = busy && !fifo_full && !abort_now && !timeout_now;
  assign fifo_push  = bus.i_x_valid && x_ready;
  assign fifo_pop   = (state_q == ISSUE) && !fifo_empty && !abort_now;
  assign fifo_flush = (state_q == CLEAR) || abort_now || timeout_now;

  dft_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_sys_clk),
    .rst_ni  (i_reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (bus.i_x),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= IDLE;
      k_q            <= '0;
      len_q          <= '0;
      n_q            <= '0;
      timer_q        <= '0;
      eng_reset_q    <= 1'b0;
      eng_wr_q       <= 1'b0;
      eng_x_q        <= '0;
      eng_k_q        <= '0;
      eng_n_q        <= '0;
      eng_len_q      <= '0;
      x_res_q        <= '0;
      result_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      eng_reset_q    <= 1'b0;
      eng_wr_q       <= 1'b0;
      result_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      timeout_err_q  <= 1'b0;

      // Abort wins over everything, including a done arriving in the same cycle.
      if (abort_now) begin
        eng_reset_q <= 1'b1;
        state_q     <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.i_start) begin
              if (start_ok) begin
                k_q         <= bus.i_k;
                len_q       <= bus.i_N;
                eng_reset_q <= 1'b1;
                state_q     <= CLEAR;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          CLEAR: begin
            n_q     <= '0;
            state_q <= ISSUE;
          end
          ISSUE: begin
            if (!fifo_empty) begin
              eng_x_q   <= fifo_dout;
              eng_n_q   <= WIDTH'(n_q);
              eng_k_q   <= k_q;
              eng_len_q <= len_q;
              eng_wr_q  <= 1'b1;
              timer_q   <= '0;
              state_q   <= WAIT;
            end
          end
          WAIT: begin
            if (bus.i_eng_done) begin
              n_q     <= n_next;
              state_q <= last_sample ? CAPTURE : ISSUE;
            end else if (timeout_now) begin
              timeout_err_q <= 1'b1;
              eng_reset_q   <= 1'b1;
              state_q       <= IDLE;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
          CAPTURE: begin
            x_res_q        <= bus.i_eng_X;
            result_valid_q <= 1'b1;
            state_q        <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_x_ready      = x_ready;
  assign bus.o_busy         = busy;
  assign bus.o_eng_reset    = eng_reset_q;
  assign bus.o_eng_wr       = eng_wr_q;
  assign bus.o_eng_x        = eng_x_q;
  assign bus.o_eng_k        = eng_k_q;
  assign bus.o_eng_n        = eng_n_q;
  assign bus.o_eng_N        = eng_len_q;
  assign bus.o_X            = x_res_q;
  assign bus.o_result_valid = result_valid_q;
  assign bus.o_cfg_err      = cfg_err_q;
  assign bus.o_timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dft_bin_scheduler.sv
// Directed bench for dft_bin_scheduler with a behavioural k=0 engine model
// (accumulates samples into the real part, pulses done after a set delay).
module tb_dft_bin_scheduler;

  logic clk;
  logic rst_n;

  dft_bin_scheduler_if #(.WIDTH(16)) bus ();

  dft_bin_scheduler dut (
    .i_sys_clk (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  int assertCount = 0;
  int failCount   = 0;

  int engDelay;
  bit engEnable;
  bit engPending;
  int engCnt;
  logic signed [15:0] engAcc;
  logic modelDone;
  logic forceDone;

  int cyc;
  int wrCount, resCount, cfgCount, rstCount, toCount;
  int firstWrCycle, toCycle, lastRstCycle;
  logic [15:0] wrN[$];
  logic signed [15:0] wrX[$];
  logic [31:0] lastX;

  assign bus.i_eng_done = modelDone | forceDone;
  assign bus.i_eng_X    = {engAcc, 16'sd0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine model: for k=0 the DFT real part is the plain sample sum.
  always @(negedge clk) begin
    modelDone = 1'b0;
    if (!rst_n || bus.o_eng_reset) begin
      engPending = 1'b0;
      engAcc     = '0;
    end else if (bus.o_eng_wr) begin
      engAcc     = engAcc + bus.o_eng_x;
      engPending = 1'b1;
      engCnt     = engDelay;
    end else if (engPending && engEnable) begin
      engCnt = engCnt - 1;
      if (engCnt <= 0) begin
        modelDone  = 1'b1;
        engPending = 1'b0;
      end
    end
  end

  // Output monitor: logs pulses and the cycle they appeared in.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.o_eng_wr === 1'b1) begin
      if (wrCount == 0) firstWrCycle = cyc;
      wrCount = wrCount + 1;
      wrN.push_back(bus.o_eng_n);
      wrX.push_back(bus.o_eng_x);
    end
    if (bus.o_result_valid === 1'b1) begin
      resCount = resCount + 1;
      lastX    = bus.o_X;
    end
    if (bus.o_cfg_err === 1'b1) cfgCount = cfgCount + 1;
    if (bus.o_eng_reset === 1'b1) begin
      rstCount     = rstCount + 1;
      lastRstCycle = cyc;
    end
    if (bus.o_timeout_err === 1'b1) begin
      toCount = toCount + 1;
      toCycle = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    wrCount  = 0;
    resCount = 0;
    cfgCount = 0;
    rstCount = 0;
    toCount  = 0;
    wrN.delete();
    wrX.delete();
  endtask

  task automatic doStart(input logic [15:0] k, input logic [15:0] n);
    bus.i_k     = k;
    bus.i_N     = n;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic sendSample(input logic signed [15:0] x);
    bit ok = 1'b0;
    bus.i_x       = x;
    bus.i_x_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (bus.o_x_ready === 1'b1) ok = 1'b1;
      tick();
    end
    bus.i_x_valid = 1'b0;
    assertCount++;
    if (!ok) begin
      failCount++;
      $display("[TB] FAIL sample_accept: got ready=0 for 2000 cycles, expected ready=1 (x=%0d)", x);
    end
  endtask

  task automatic waitResult(input int budget);
    for (int i = 0; i < budget && resCount == 0; i++) tick();
    assertCount++;
    if (resCount == 0) begin
      failCount++;
      $display("[TB] FAIL result_wait: got no result_valid in %0d cycles, expected one", budget);
    end
  endtask

  task automatic waitWr(input int target, input int budget);
    for (int i = 0; i < budget && wrCount < target; i++) tick();
    assertCount++;
    if (wrCount < target) begin
      failCount++;
      $display("[TB] FAIL wr_wait: got %0d writes, expected %0d", wrCount, target);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n         = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_k       = '0;
    bus.i_N       = '0;
    bus.i_abort   = 1'b0;
    bus.i_x       = '0;
    bus.i_x_valid = 1'b0;
    forceDone     = 1'b0;
    engEnable     = 1'b1;
    engDelay      = 16;
    engAcc        = '0;
    engPending    = 1'b0;
    cyc           = 0;
    clearLog();
    repeat (3) @(posedge clk);
    #1;
    assertCount++;
    if ({bus.o_busy, bus.o_x_ready, bus.o_eng_wr, bus.o_eng_reset, bus.o_result_valid,
         bus.o_cfg_err, bus.o_timeout_err} !== 7'b0) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b, expected 0000000",
               {bus.o_busy, bus.o_x_ready, bus.o_eng_wr, bus.o_eng_reset, bus.o_result_valid,
                bus.o_cfg_err, bus.o_timeout_err});
    end
    assertCount++;
    if ({bus.o_X, bus.o_eng_x, bus.o_eng_n, bus.o_eng_k, bus.o_eng_N} !== 96'b0) begin
      failCount++;
      $display("[TB] FAIL reset_data: got X=%h eng_x=%h n=%h k=%h N=%h, expected all 0",
               bus.o_X, bus.o_eng_x, bus.o_eng_n, bus.o_eng_k, bus.o_eng_N);
    end
    rst_n = 1'b1;
    tick();
    tick();
    assertCount++;
    if (bus.o_busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL idle_after_reset: got busy=%b, expected 0", bus.o_busy);
    end
  endtask

  task automatic test_basic_frame();
    logic signed [15:0] xs [4];
    xs = '{16'sd0, -16'sd1, 16'sd0, 16'sd1};
    $display("[TB] test_basic_frame");
    clearLog();
    engDelay  = 16;
    engEnable = 1'b1;
    doStart(16'd0, 16'd4);
    assertCount++;
    if (bus.o_busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL busy_after_start: got %b, expected 1", bus.o_busy);
    end
    assertCount++;
    if (bus.o_eng_reset !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL clear_eng_reset: got %b, expected 1", bus.o_eng_reset);
    end
    for (int i = 0; i < 4; i++) sendSample(xs[i]);
    waitResult(500);
    assertCount++;
    if (wrCount != 4) begin
      failCount++;
      $display("[TB] FAIL basic_wr_count: got %0d, expected 4", wrCount);
    end
    for (int i = 0; i < 4 && i < wrN.size(); i++) begin
      assertCount++;
      if (wrN[i] !== 16'(i) || wrX[i] !== xs[i]) begin
        failCount++;
        $display("[TB] FAIL basic_wr_%0d: got n=%0d x=%0d, expected n=%0d x=%0d",
                 i, wrN[i], wrX[i], i, xs[i]);
      end
    end
    assertCount++;
    if (resCount != 1 || lastX !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL basic_result: got count=%0d X=%h, expected 1 and 00000000", resCount, lastX);
    end
    assertCount++;
    if (bus.o_eng_N !== 16'd4 || bus.o_eng_k !== 16'd0 || bus.o_busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL basic_hold: got N=%0d k=%0d busy=%b, expected 4 0 0",
               bus.o_eng_N, bus.o_eng_k, bus.o_busy);
    end
  endtask

  task automatic test_cfg_errors();
    logic [15:0] ks [3];
    logic [15:0] ns [3];
    ks = '{16'd0, 16'd4, 16'd0};
    ns = '{16'd0, 16'd4, 16'd1025};
    $display("[TB] test_cfg_errors");
    clearLog();
    for (int i = 0; i < 3; i++) begin
      doStart(ks[i], ns[i]);
      assertCount++;
      if (bus.o_cfg_err !== 1'b1 || bus.o_busy !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL cfg_err_%0d: got err=%b busy=%b, expected 1 0", i, bus.o_cfg_err, bus.o_busy);
      end
      tick();
      assertCount++;
      if (bus.o_cfg_err !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL cfg_err_pulse_%0d: got %b, expected 0", i, bus.o_cfg_err);
      end
    end
    assertCount++;
    if (wrCount != 0 || cfgCount != 3) begin
      failCount++;
      $display("[TB] FAIL cfg_side_effects: got wr=%0d err=%0d, expected 0 3", wrCount, cfgCount);
    end
    doStart(16'd0, 16'd1);
    assertCount++;
    if (bus.o_cfg_err !== 1'b0 || bus.o_busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL cfg_n1_start: got err=%b busy=%b, expected 0 1", bus.o_cfg_err, bus.o_busy);
    end
    doStart(16'd5, 16'd0);
    assertCount++;
    if (bus.o_cfg_err !== 1'b0 || bus.o_busy !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL start_while_busy: got err=%b busy=%b, expected 0 1", bus.o_cfg_err, bus.o_busy);
    end
    sendSample(16'sd5);
    waitResult(200);
    assertCount++;
    if (wrCount != 1 || lastX !== {16'sd5, 16'sd0}) begin
      failCount++;
      $display("[TB] FAIL n1_frame: got wr=%0d X=%h, expected 1 00050000", wrCount, lastX);
    end
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    $display("[TB] test_back_to_back");
    clearLog();
    engDelay  = 2;
    engEnable = 1'b0;
    doStart(16'd0, 16'd8);
    for (int c = 0; c < 8; c++) begin
      bus.i_x_valid = (accepted < 6);
      bus.i_x       = 16'(10 + accepted);
      if (bus.o_x_ready === 1'b1 && accepted < 6) begin
        tick();
        accepted++;
      end else begin
        tick();
      end
    end
    bus.i_x_valid = 1'b0;
    assertCount++;
    if (accepted != 5 || bus.o_x_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL stall_accept: got accepted=%0d ready=%b, expected 5 0", accepted, bus.o_x_ready);
    end
    assertCount++;
    if (wrCount != 1 || (wrX.size() > 0 && wrX[0] !== 16'sd10)) begin
      failCount++;
      $display("[TB] FAIL stall_issue: got wr=%0d, expected 1 write of x=10", wrCount);
    end
    engEnable = 1'b1;
    for (int i = 5; i < 8; i++) sendSample(16'(10 + i));
    waitResult(1000);
    assertCount++;
    if (wrCount != 8) begin
      failCount++;
      $display("[TB] FAIL b2b_wr_count: got %0d, expected 8", wrCount);
    end
    for (int i = 0; i < 8 && i < wrN.size(); i++) begin
      assertCount++;
      if (wrN[i] !== 16'(i) || wrX[i] !== 16'(10 + i)) begin
        failCount++;
        $display("[TB] FAIL b2b_wr_%0d: got n=%0d x=%0d, expected n=%0d x=%0d",
                 i, wrN[i], wrX[i], i, 10 + i);
      end
    end
    assertCount++;
    if (lastX !== {16'sd108, 16'sd0}) begin
      failCount++;
      $display("[TB] FAIL b2b_result: got %h, expected 006c0000", lastX);
    end
  endtask

  task automatic test_timeout();
    $display("[TB] test_timeout");
    clearLog();
    engEnable = 1'b0;
    doStart(16'd0, 16'd2);
    sendSample(16'sd7);
    for (int i = 0; i < 400 && toCount == 0; i++) tick();
    assertCount++;
    if (toCount == 0) begin
      failCount++;
      $display("[TB] FAIL timeout_seen: got no timeout_err in 400 cycles, expected one");
    end
    assertCount++;
    if (toCycle - firstWrCycle != 256) begin
      failCount++;
      $display("[TB] FAIL timeout_latency: got %0d cycles, expected 256", toCycle - firstWrCycle);
    end
    assertCount++;
    if (rstCount != 2 || lastRstCycle != toCycle) begin
      failCount++;
      $display("[TB] FAIL timeout_eng_reset: got count=%0d at %0d, expected 2 at %0d",
               rstCount, lastRstCycle, toCycle);
    end
    assertCount++;
    if (bus.o_busy !== 1'b0 || bus.o_x_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL timeout_idle: got busy=%b ready=%b, expected 0 0", bus.o_busy, bus.o_x_ready);
    end
    repeat (3) tick();
    assertCount++;
    if (toCount != 1 || wrCount != 1 || resCount != 0) begin
      failCount++;
      $display("[TB] FAIL timeout_after: got to=%0d wr=%0d res=%0d, expected 1 1 0", toCount, wrCount, resCount);
    end
    engEnable = 1'b1;
  endtask

  task automatic test_abort();
    $display("[TB] test_abort");
    clearLog();
    engDelay  = 3;
    engEnable = 1'b1;
    doStart(16'd0, 16'd4);
    for (int i = 1; i <= 4; i++) sendSample(16'(i));
    waitWr(3, 200);
    engEnable   = 1'b0;
    forceDone   = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    forceDone   = 1'b0;
    bus.i_abort = 1'b0;
    assertCount++;
    if (bus.o_busy !== 1'b0 || bus.o_eng_reset !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL abort_response: got busy=%b eng_reset=%b, expected 0 1", bus.o_busy, bus.o_eng_reset);
    end
    engEnable = 1'b1;
    repeat (10) tick();
    assertCount++;
    if (wrCount != 3 || resCount != 0) begin
      failCount++;
      $display("[TB] FAIL abort_quiet: got wr=%0d res=%0d, expected 3 0", wrCount, resCount);
    end
    assertCount++;
    if (dut.u_fifo.empty_o !== 1'b1 || bus.o_x_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_flush: got empty=%b ready=%b, expected 1 0", dut.u_fifo.empty_o, bus.o_x_ready);
    end
    clearLog();
    doStart(16'd0, 16'd2);
    sendSample(16'sd3);
    sendSample(16'sd4);
    waitResult(200);
    assertCount++;
    if (wrCount != 2 || wrN[0] !== 16'd0 || wrX[0] !== 16'sd3 || lastX !== {16'sd7, 16'sd0}) begin
      failCount++;
      $display("[TB] FAIL abort_restart: got wr=%0d X=%h, expected 2 00070000", wrCount, lastX);
    end
  endtask

  task automatic test_async_reset();
    $display("[TB] test_async_reset");
    clearLog();
    engDelay  = 16;
    engEnable = 1'b1;
    doStart(16'd0, 16'd4);
    sendSample(16'sd9);
    waitWr(1, 100);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    assertCount++;
    if ({bus.o_busy, bus.o_x_ready, bus.o_eng_wr, bus.o_eng_reset, bus.o_result_valid} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL async_flags: got %b, expected 00000",
               {bus.o_busy, bus.o_x_ready, bus.o_eng_wr, bus.o_eng_reset, bus.o_result_valid});
    end
    assertCount++;
    if ({bus.o_X, bus.o_eng_x, bus.o_eng_N} !== 64'b0) begin
      failCount++;
      $display("[TB] FAIL async_data: got X=%h eng_x=%h N=%h, expected all 0", bus.o_X, bus.o_eng_x, bus.o_eng_N);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    clearLog();
    doStart(16'd0, 16'd4);
    for (int i = 1; i <= 4; i++) sendSample(16'(i));
    waitResult(500);
    assertCount++;
    if (wrCount != 4 || lastX !== {16'sd10, 16'sd0}) begin
      failCount++;
      $display("[TB] FAIL post_reset_frame: got wr=%0d X=%h, expected 4 000a0000", wrCount, lastX);
    end
    for (int i = 0; i < 4 && i < wrN.size(); i++) begin
      assertCount++;
      if (wrN[i] !== 16'(i)) begin
        failCount++;
        $display("[TB] FAIL post_reset_n_%0d: got %0d, expected %0d", i, wrN[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_cfg_errors();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
